// File: rtl/sm3_expnd_core.sv
// -----------------------------------------------------------------------------
// sm3_expnd_core
//
// SM3 message expansion. This block takes the 32-bit padded message stream from
// sm3_pad_core, sixteen words per 512-bit block. It then produces the expanded
// word pair (W_j, W'_j) for j = 0..63. The compression stage consumes the pairs
// at its own pace.
//
// A 16-entry sliding window holds W_j..W_(j+15). After a block is loaded,
// win[0] is always the current W_j. Each advance does three things: it shifts
// the window down one entry, it writes the next expanded word W_(j+16) into the
// top entry, and it increments j. W'_j = W_j ^ W_(j+4) is win[0] ^ win[4], so
// W_64..W_67 are never needed as separate storage.
//
// Loading and expansion do not overlap. The input is ready in IDLE and LOAD and
// not ready in EXPND. The shortest block period is therefore 16 + 64 cycles.
//
// Ports
//   clk                   clock, rising edge
//   rst_n                 asynchronous reset, active low
//   pad_inpt_d_i   [31:0] padded message word, big-endian word order
//   pad_inpt_vld_i        message word valid
//   pad_inpt_lst_i        last word of the final padded block
//   pad_inpt_rdy_o        ready to accept a message word (IDLE or LOAD)
//   expnd_otpt_wj_o[31:0] expanded word W_j
//   expnd_otpt_wjj_o[31:0] expanded word W'_j = W_j ^ W_(j+4)
//   expnd_otpt_vld_o      W_j / W'_j valid (high for the whole EXPND state)
//   expnd_otpt_ena_i      downstream enable; low holds the current pair
//   expnd_otpt_blk_lst_o  current pair is j = 63 of a block
//   expnd_otpt_lst_o      current pair is j = 63 of the message's final block
// -----------------------------------------------------------------------------
module sm3_expnd_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pad_inpt_d_i,
  input  logic        pad_inpt_vld_i,
  input  logic        pad_inpt_lst_i,
  output logic        pad_inpt_rdy_o,
  output logic [31:0] expnd_otpt_wj_o,
  output logic [31:0] expnd_otpt_wjj_o,
  output logic        expnd_otpt_vld_o,
  input  logic        expnd_otpt_ena_i,
  output logic        expnd_otpt_blk_lst_o,
  output logic        expnd_otpt_lst_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXPND = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [5:0]  j_q, j_d;
  logic        lst_q, lst_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];

  logic        acc;
  logic        adv;
  logic [31:0] w_new;

  // Permutation P1(x) = x ^ (x <<< 15) ^ (x <<< 23). The rotates are fixed, so
  // each one is only a rewiring of the bits.
  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ {x[16:0], x[31:17]} ^ {x[8:0], x[31:9]};
  endfunction

  // Next expanded word W_(j+16), built from the current window:
  //   W_j = win[0], W_(j+3) = win[3], W_(j+7) = win[7],
  //   W_(j+10) = win[10], W_(j+13) = win[13].
  assign w_new = p1(win_q[0] ^ win_q[7] ^ {win_q[13][16:0], win_q[13][31:17]})
               ^ {win_q[3][24:0], win_q[3][31:25]}
               ^ win_q[10];

  // Handshake qualifiers. Ready depends only on the state register, so the
  // accept term has no input-to-output path.
  assign acc = pad_inpt_vld_i && pad_inpt_rdy_o;
  assign adv = (state_q == EXPND) && expnd_otpt_ena_i;

  // Next-state logic for the control and the window.
  always_comb begin
    // NOTE: every variable gets a default before the case statement. A path
    // that assigns nothing then holds the register value and cannot infer a latch.
    state_d = state_q;
    lcnt_d  = lcnt_q;
    j_d     = j_q;
    lst_d   = lst_q;
    win_d   = win_q;

    unique case (state_q)
      IDLE, LOAD: begin
        if (acc) begin
          win_d[lcnt_q] = pad_inpt_d_i;
          lcnt_d        = lcnt_q + 4'd1;
          if (lcnt_q == 4'd15) begin
            // This is the sixteenth word, so the block is complete. lcnt wraps
            // to 0 by itself. The last-block flag is taken from this word only.
            state_d = EXPND;
            j_d     = 6'd0;
            lst_d   = pad_inpt_lst_i;
          end else begin
            state_d = LOAD;
          end
        end
      end

      EXPND: begin
        if (adv) begin
          for (int k = 0; k < 15; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[15] = w_new;
          j_d       = j_q + 6'd1;
          if (j_q == 6'd63) begin
            state_d = IDLE;
            lst_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lcnt_q  <= 4'd0;
      j_q     <= 6'd0;
      lst_q   <= 1'b0;
      // NOTE: the window is reset explicitly. W_j and W'_j are read directly
      // from win[0] and win[4], and they must read as zero during reset. The
      // window therefore cannot be an unreset RAM.
      for (int k = 0; k < 16; k++) begin
        win_q[k] <= 32'd0;
      end
    end else begin
      // NOTE: all sequential state uses non-blocking assignments. The
      // window shift then reads the old values of every entry.
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      j_q     <= j_d;
      lst_q   <= lst_d;
      win_q   <= win_d;
    end
  end

  // Outputs. Every output is decoded from registers only.
  assign pad_inpt_rdy_o       = (state_q != EXPND);
  assign expnd_otpt_vld_o     = (state_q == EXPND);
  assign expnd_otpt_wj_o      = win_q[0];
  assign expnd_otpt_wjj_o     = win_q[0] ^ win_q[4];
  assign expnd_otpt_blk_lst_o = (state_q == EXPND) && (j_q == 6'd63);
  assign expnd_otpt_lst_o     = (state_q == EXPND) && (j_q == 6'd63) && lst_q;

endmodule

// File: tb/tb_sm3_expnd_core.sv
// -----------------------------------------------------------------------------
// tb_sm3_expnd_core
//
// Self-checking bench for sm3_expnd_core. For each block that is fully
// accepted, a reference model expands the sixteen words into the complete
// W[0..67] array. The model then queues the 64 expected output pairs, each with
// its block-last and message-last flags. On every falling edge the compare
// step checks the DUT against the head of the queue. It pops the head only when
// the enable is high, so a stall must hold the outputs unchanged.
// -----------------------------------------------------------------------------
module tb_sm3_expnd_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pad_d = 32'd0;
  logic        pad_vld = 1'b0;
  logic        pad_lst = 1'b0;
  logic        rdy;
  logic [31:0] wj;
  logic [31:0] wjj;
  logic        vld;
  logic        ena = 1'b1;
  logic        blk_lst;
  logic        lst;

  sm3_expnd_core dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pad_inpt_d_i         (pad_d),
    .pad_inpt_vld_i       (pad_vld),
    .pad_inpt_lst_i       (pad_lst),
    .pad_inpt_rdy_o       (rdy),
    .expnd_otpt_wj_o      (wj),
    .expnd_otpt_wjj_o     (wjj),
    .expnd_otpt_vld_o     (vld),
    .expnd_otpt_ena_i     (ena),
    .expnd_otpt_blk_lst_o (blk_lst),
    .expnd_otpt_lst_o     (lst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wj;
    logic [31:0] wjj;
    logic        bl;
    logic        l;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        acc_s = 1'b0;
  logic        ena_rand = 1'b0;
  int          stall_j = -1;
  int          stall_left = 0;
  logic [31:0] abc[16];
  logic [31:0] rm[16];
  logic [31:0] mw[68];

  // ---------------------------------------------------------------- model ---
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  task automatic model_w(input logic [31:0] m[16], output logic [31:0] w[68]);
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 68; i++)
      w[i] = p1(w[i-16] ^ w[i-9] ^ rotl(w[i-3], 15)) ^ rotl(w[i-13], 7) ^ w[i-6];
  endtask

  task automatic push_block(input logic [31:0] m[16], input logic last);
    logic [31:0] w[68];
    model_w(m, w);
    for (int j = 0; j < 64; j++)
      q.push_back('{w[j], w[j] ^ w[j+4], j == 63, (j == 63) && last});
  endtask

  // --------------------------------------------------------------- checks ---
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare step, called once per cycle at the falling edge.
  task automatic compare();
    int jj;
    acc_s = pad_vld && rdy;
    if (!rst_n) begin
      check1("rst_vld", vld, 1'b0);
      check1("rst_rdy", rdy, 1'b1);
      check1("rst_blk_lst", blk_lst, 1'b0);
      check1("rst_lst", lst, 1'b0);
      check("rst_wj", wj, 32'd0);
      check("rst_wjj", wjj, 32'd0);
      return;
    end
    check1("rdy_vs_vld", rdy, !vld);
    if (vld) begin
      if (q.size() == 0) begin
        check1("vld_extra", vld, 1'b0);
      end else begin
        jj = 64 - q.size();
        check($sformatf("wj[%0d]", jj), wj, q[0].wj);
        check($sformatf("wjj[%0d]", jj), wjj, q[0].wjj);
        check1($sformatf("blk_lst[%0d]", jj), blk_lst, q[0].bl);
        check1($sformatf("lst[%0d]", jj), lst, q[0].l);
        if (ena) void'(q.pop_front());
      end
    end else begin
      if (q.size() != 0) check1("vld_missing", vld, 1'b1);
      check1("idle_blk_lst", blk_lst, 1'b0);
      check1("idle_lst", lst, 1'b0);
    end
  endtask

  // The enable is driven shortly after the rising edge. A directed stall holds
  // it low for 5 cycles once the model says the DUT is showing W_stall_j.
  task automatic drive_ena();
    if (stall_left > 0) begin
      ena = 1'b0;
      stall_left--;
    end else if (stall_j >= 0 && q.size() != 0 && (64 - q.size()) == stall_j) begin
      ena        = 1'b0;
      stall_left = 4;
      stall_j    = -1;
    end else begin
      ena = ena_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    drive_ena();
  endtask

  // Sends the first nw words of a block with random gaps of up to max_gap
  // cycles. A full block queues its 64 expected pairs.
  task automatic send_block(input logic [31:0] m[16], input logic [15:0] lstv,
                            input int max_gap, input int nw);
    int guard;
    for (int w = 0; w < nw; w++) begin
      pad_vld = 1'b0;
      pad_lst = 1'b0;
      repeat ($urandom_range(0, max_gap)) tick();
      pad_d   = m[w];
      pad_lst = lstv[w];
      pad_vld = 1'b1;
      guard   = 0;
      do begin
        tick();
        guard++;
      end while (!acc_s && guard < 500);
      if (!acc_s) check1($sformatf("accept_timeout_w%0d", w), acc_s, 1'b1);
    end
    pad_vld = 1'b0;
    pad_lst = 1'b0;
    if (nw == 16) push_block(m, lstv[15]);
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || vld) && g < 2000) begin
      tick();
      g++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // ----------------------------------------------------------------- main ---
  initial begin
    int g;
    logic [15:0] lstv;

    abc[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) abc[i] = 32'h0;
    abc[15] = 32'h00000018;

    // Pin the model to known SM3 values for "abc".
    model_w(abc, mw);
    check("model_w0", mw[0], 32'h61626380);
    check("model_wjj0", mw[0] ^ mw[4], 32'h61626380);
    check("model_w16", mw[16], 32'h9092E200);

    // Reset state.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // "abc", single block, enable held high.
    ena_rand = 1'b0;
    send_block(abc, 16'h8000, 0, 16);
    drain();

    // Last flag on word 7 only is ignored.
    send_block(abc, 16'h0080, 1, 16);
    drain();

    // Gapped input plus a 5-cycle stall at j=20.
    stall_j = 20;
    send_block(abc, 16'h8000, 2, 16);
    drain();
    check1("stall_taken", stall_j < 0, 1'b1);

    // Two blocks back to back. Block 2 word 0 waits while block 1 expands.
    for (int i = 0; i < 16; i++) rm[i] = $urandom();
    send_block(rm, 16'h0000, 0, 16);
    for (int i = 0; i < 16; i++) rm[i] = $urandom();
    send_block(rm, 16'h8000, 0, 16);
    drain();

    // Random blocks, random gaps, random enable, random last flags.
    ena_rand = 1'b1;
    repeat (6) begin
      for (int i = 0; i < 16; i++) rm[i] = $urandom();
      lstv = 16'($urandom());
      send_block(rm, lstv, 2, 16);
    end
    drain();
    ena_rand = 1'b0;

    // Reset during LOAD discards the partial block.
    for (int i = 0; i < 16; i++) rm[i] = $urandom();
    send_block(rm, 16'hFFFF, 1, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check1("midload_rst_rdy", rdy, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    send_block(abc, 16'h8000, 0, 16);
    drain();

    // Reset at j=30. vld drops at once, and the next "abc" block is correct.
    send_block(abc, 16'h8000, 0, 16);
    g = 0;
    while (!(q.size() != 0 && (64 - q.size()) == 30) && g < 200) begin
      tick();
      g++;
    end
    check("reach_j30", 32'(64 - q.size()), 32'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_vld", vld, 1'b0);
    check1("async_rst_rdy", rdy, 1'b1);
    check("async_rst_wj", wj, 32'd0);
    check("async_rst_wjj", wjj, 32'd0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send_block(abc, 16'h8000, 1, 16);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm3_expnd_core.md
SM3_EXPND_CORE -- requirements
Module: sm3_expnd_core

Interface
REQ-001 Parameters: none; the datapath is fixed at 32 bits, matching the SM3_INPT_DW_32 pad output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pad_inpt_d_i  input  32  padded message word from sm3_pad_core pad_otpt_d_o, big-endian word order.
REQ-005 pad_inpt_vld_i  input  1  word valid, from pad_otpt_vld_o.
REQ-006 pad_inpt_lst_i  input  1  last word of the last padded block, from pad_otpt_lst_o.
REQ-007 pad_inpt_rdy_o  output  1  ready; drives the pad core's pad_otpt_ena_i.
REQ-008 expnd_otpt_wj_o  output  32  expanded word W_j.
REQ-009 expnd_otpt_wjj_o  output  32  expanded word W'_j = W_j ^ W_(j+4).
REQ-010 expnd_otpt_vld_o  output  1  W_j and W'_j are valid.
REQ-011 expnd_otpt_ena_i  input  1  downstream (compression) enable; low stalls the output.
REQ-012 expnd_otpt_blk_lst_o  output  1  current word is j=63 of the block.
REQ-013 expnd_otpt_lst_o  output  1  current word is j=63 of the message's final block.

Function
REQ-014 States: IDLE, LOAD, EXPND; a 16-entry 32-bit window win[0..15] holds W_j..W_(j+15).
REQ-015 Counters: 4-bit load count lcnt; 6-bit round count j; 1-bit latched last flag lst_q.
REQ-016 pad_inpt_rdy_o = 1 in IDLE and LOAD, and 0 in EXPND.
REQ-017 A word is accepted only when pad_inpt_vld_i && pad_inpt_rdy_o; pad_inpt_vld_i without rdy is ignored.
REQ-018 IDLE -> LOAD on the first accepted word; that word is written to win[lcnt] and lcnt increments.
REQ-019 LOAD: each accepted word is written to win[lcnt] and lcnt increments.
REQ-020 On the 16th accepted word (lcnt==15): go to EXPND, set j=0, lcnt wraps to 0.
REQ-021 pad_inpt_lst_i is sampled into lst_q only on the 16th word; on any other word it is ignored.
REQ-022 expnd_otpt_vld_o = 1 exactly while in EXPND; it rises the cycle after the 16th word is accepted (latency 1 clk).
REQ-023 Outputs are taken directly from registers: wj = win[0], wjj = win[0] ^ win[4]; there is no combinational path from any input to any output.
REQ-024 Advance when EXPND && expnd_otpt_ena_i: win shifts down one entry (win[k] <= win[k+1]), j increments.
REQ-025 On each advance, win[15] <= P1(win[0]^win[7]^(win[13]<<<15)) ^ (win[3]<<<7) ^ win[10].
REQ-026 P1(x) = x ^ (x<<<15) ^ (x<<<23); all rotates are 32-bit circular; XOR only, no carries.
REQ-027 expnd_otpt_ena_i = 0 in EXPND: window, j, and all outputs hold unchanged; vld stays 1.
REQ-028 expnd_otpt_blk_lst_o = (EXPND && j==63).
REQ-029 expnd_otpt_lst_o = (EXPND && j==63 && lst_q).
REQ-030 Advance at j==63: go to IDLE and clear lst_q; vld falls the next cycle.
REQ-031 Minimum block period is 80 clk (16 load + 64 expand); there is no overlap of load and expand.
REQ-032 A new block can be accepted in the first cycle after returning to IDLE.

Reset
REQ-033 While rst_n=0, asynchronously: state=IDLE, lcnt=0, j=0, lst_q=0, win[*]=0.
REQ-034 Output values while in reset: vld, blk_lst, lst = 0; wj, wjj = 0; pad_inpt_rdy_o = 1.
REQ-035 Reset asserted mid-LOAD or mid-EXPND discards the partial block; after release, the next accepted word is word 0.

Verification
REQ-036 Scenario "abc", single block, ena=1.
- Stimulus: words 0x61626380, 14 x 0x00000000, 0x00000018 with lst on the last word.
- Response at j=0: wj=0x61626380, wjj=0x61626380.
- Response at j=16: wj=0x9092E200.
- Response at j=63: blk_lst=1, lst=1; total 64 valid cycles.
REQ-037 Two back-to-back blocks, lst only on block 2 -> block 1 j=63 has blk_lst=1, lst=0; block 2 j=63 has lst=1.
REQ-038 Gapped input: vld deasserted randomly during LOAD -> identical W sequence; rdy stays 1 throughout LOAD.
REQ-039 expnd_otpt_ena_i held low 5 clk at j=20 -> outputs frozen at W_20 for 5 clk, then the sequence resumes without loss.
REQ-040 rst_n pulsed low at j=30 -> vld=0 immediately; the next full block produces the correct "abc" vectors.
REQ-041 pad_inpt_lst_i asserted on word 7 only -> lst_q=0; lst stays 0 at j=63.
